// File: rtl/audio_pkg.sv
// Shared types and widths for the audio sample scheduler.
// Used by the fetch unit and the top-level sequencer.
package audio_pkg;

  localparam int IN_W        = 16;
  localparam int MIX_W       = 17;
  localparam int OUT_W       = 24;
  localparam int CNT_W       = 6;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ_PCM = 2'd1,
    ST_REQ_PSG = 2'd2,
    ST_MIX     = 2'd3
  } state_t;

  // Sign-extend to mix width, then arithmetic attenuation.
  function automatic logic signed [MIX_W-1:0] att_shift(
    input logic [IN_W-1:0] x,
    input logic [3:0]      att
  );
    logic signed [MIX_W-1:0] e;
    e = {x[IN_W-1], x};
    return e >>> att;
  endfunction

endpackage

// File: rtl/audio_src_fetch.sv
// One source handshake: level req, ack or timeout,
// capture registers and saturating underrun counter.
module audio_src_fetch
  import audio_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stat_clr,
  input  logic            ack,
  input  logic [IN_W-1:0] in_left,
  input  logic [IN_W-1:0] in_right,
  output logic            req,
  output logic            done,
  output logic [IN_W-1:0] left,
  output logic [IN_W-1:0] right,
  output logic [7:0]      underruns
);

  logic [CNT_W-1:0] cnt;
  logic             tmo;

  assign tmo  = (cnt == CNT_W'(TIMEOUT - 1));
  assign done = req & (ack | tmo);

  // Request level and wait counter; cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      req <= 1'b1;
      cnt <= '0;
    end else if (req) begin
      cnt <= cnt + 1'b1;
      if (done) req <= 1'b0;
    end
  end

  // Capture on ack; an ack on the timeout cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left  <= '0;
      right <= '0;
    end else if (req & ack) begin
      left  <= in_left;
      right <= in_right;
    end else if (req & tmo) begin
      left  <= '0;
      right <= '0;
    end
  end

  // Saturating underrun count; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underruns <= '0;
    end else if (stat_clr) begin
      underruns <= '0;
    end else if (req & tmo & ~ack & (underruns != 8'hFF)) begin
      underruns <= underruns + 1'b1;
    end
  end

endmodule

// File: rtl/audio_sample_sched.sv
// Per-frame PCM/PSG fetch sequencer and mixer
// feeding stable 24-bit words to the DAC interface.
module audio_sample_sched
  import audio_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        next_sample,
  output logic        pcm_req,
  input  logic        pcm_ack,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  output logic        psg_req,
  input  logic        psg_ack,
  input  logic [15:0] psg_left,
  input  logic [15:0] psg_right,
  input  logic [3:0]  pcm_att,
  input  logic [3:0]  psg_att,
  input  logic        mute,
  output logic [23:0] left_data,
  output logic [23:0] right_data,
  output logic [7:0]  pcm_underruns,
  output logic [7:0]  psg_underruns,
  output logic        overrun,
  input  logic        stat_clr
);

  state_t state;
  state_t state_nx;

  logic pcm_start;
  logic psg_start;
  logic pcm_done;
  logic psg_done;

  logic [IN_W-1:0] pcm_l;
  logic [IN_W-1:0] pcm_r;
  logic [IN_W-1:0] psg_l;
  logic [IN_W-1:0] psg_r;

  logic signed [MIX_W-1:0] sum_l;
  logic signed [MIX_W-1:0] sum_r;

  assign pcm_start = (state == ST_IDLE) & next_sample;
  assign psg_start = (state == ST_REQ_PCM) & pcm_done;

  audio_src_fetch #(.TIMEOUT(TIMEOUT)) u_pcm (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (pcm_start),
    .stat_clr  (stat_clr),
    .ack       (pcm_ack),
    .in_left   (pcm_left),
    .in_right  (pcm_right),
    .req       (pcm_req),
    .done      (pcm_done),
    .left      (pcm_l),
    .right     (pcm_r),
    .underruns (pcm_underruns)
  );

  audio_src_fetch #(.TIMEOUT(TIMEOUT)) u_psg (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (psg_start),
    .stat_clr  (stat_clr),
    .ack       (psg_ack),
    .in_left   (psg_left),
    .in_right  (psg_right),
    .req       (psg_req),
    .done      (psg_done),
    .left      (psg_l),
    .right     (psg_r),
    .underruns (psg_underruns)
  );

  // Next-state: each fetch phase ends on its source's done.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (next_sample) state_nx = ST_REQ_PCM;
      ST_REQ_PCM: if (pcm_done)    state_nx = ST_REQ_PSG;
      ST_REQ_PSG: if (psg_done)    state_nx = ST_MIX;
      ST_MIX:                      state_nx = ST_IDLE;
      default:                     state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Exact 17-bit sums of the attenuated operands.
  always_comb begin
    sum_l = att_shift(pcm_l, pcm_att) + att_shift(psg_l, psg_att);
    sum_r = att_shift(pcm_r, pcm_att) + att_shift(psg_r, psg_att);
  end

  // Output words change only in MIX and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_data  <= '0;
      right_data <= '0;
    end else if (state == ST_MIX) begin
      if (mute) begin
        left_data  <= '0;
        right_data <= '0;
      end else begin
        left_data  <= {sum_l, 7'b0};
        right_data <= {sum_r, 7'b0};
      end
    end
  end

  // Sticky overrun on a frame pulse while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 overrun <= 1'b0;
    else if (stat_clr)                          overrun <= 1'b0;
    else if (next_sample && state != ST_IDLE)   overrun <= 1'b1;
  end

endmodule

// File: tb/tb_audio_sample_sched.sv
// Directed bench for audio_sample_sched with a
// queue of expected mixes popped at frame end.
module tb_audio_sample_sched;

  localparam int T = 32;

  logic        clk;
  logic        rst_n;
  logic        next_sample;
  logic        pcm_req;
  logic        pcm_ack;
  logic [15:0] pcm_left;
  logic [15:0] pcm_right;
  logic        psg_req;
  logic        psg_ack;
  logic [15:0] psg_left;
  logic [15:0] psg_right;
  logic [3:0]  pcm_att;
  logic [3:0]  psg_att;
  logic        mute;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic [7:0]  pcm_underruns;
  logic [7:0]  psg_underruns;
  logic        overrun;
  logic        stat_clr;

  int passed = 0;
  int total  = 0;

  logic [47:0] sb[$];

  // 0 = ack at once, 1 = never ack, 2 = ack after dly cycles
  int pcm_mode = 0;
  int psg_mode = 0;
  int pcm_dly  = 0;
  int psg_dly  = 0;
  int pcm_cyc  = 0;
  int psg_cyc  = 0;
  int pcm_rises = 0;
  logic pcm_q = 1'b0;

  audio_sample_sched #(.TIMEOUT(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_sample   (next_sample),
    .pcm_req       (pcm_req),
    .pcm_ack       (pcm_ack),
    .pcm_left      (pcm_left),
    .pcm_right     (pcm_right),
    .psg_req       (psg_req),
    .psg_ack       (psg_ack),
    .psg_left      (psg_left),
    .psg_right     (psg_right),
    .pcm_att       (pcm_att),
    .psg_att       (psg_att),
    .mute          (mute),
    .left_data     (left_data),
    .right_data    (right_data),
    .pcm_underruns (pcm_underruns),
    .psg_underruns (psg_underruns),
    .overrun       (overrun),
    .stat_clr      (stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pcm_ack = pcm_req &&
    (pcm_mode == 0 || (pcm_mode == 2 && pcm_cyc == pcm_dly));
  assign psg_ack = psg_req &&
    (psg_mode == 0 || (psg_mode == 2 && psg_cyc == psg_dly));

  always @(posedge clk) begin
    pcm_cyc <= pcm_req ? pcm_cyc + 1 : 0;
    psg_cyc <= psg_req ? psg_cyc + 1 : 0;
    pcm_q   <= pcm_req;
    if (pcm_req && !pcm_q) pcm_rises <= pcm_rises + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pulse();
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
  endtask

  // Wait for psg_req to rise and fall, then one MIX cycle.
  task automatic wait_done(input string tag);
    int  n;
    bit  seen;
    bit  ok;
    n = 0; seen = 0; ok = 0;
    while (n < 200 && !ok) begin
      if (psg_req) seen = 1;
      else if (seen) ok = 1;
      if (!ok) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic pop_chk(input string tag);
    logic [47:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_l"}, {8'd0, left_data},  {8'd0, e[47:24]});
      chk({tag, "_r"}, {8'd0, right_data}, {8'd0, e[23:0]});
    end
  endtask

  task automatic frame(input string tag,
                       input logic [23:0] el,
                       input logic [23:0] er);
    sb.push_back({el, er});
    pulse();
    wait_done(tag);
    pop_chk(tag);
  endtask

  task automatic set_src(input logic [15:0] pl, input logic [15:0] pr,
                         input logic [15:0] sl, input logic [15:0] sr);
    pcm_left = pl; pcm_right = pr;
    psg_left = sl; psg_right = sr;
  endtask

  initial begin
    int c;
    int r0;
    rst_n = 1'b0;
    next_sample = 1'b0;
    stat_clr = 1'b0;
    mute = 1'b0;
    pcm_att = 4'd0;
    psg_att = 4'd0;
    set_src(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_pcm_req", {31'd0, pcm_req}, 32'd0);
    chk("rst_psg_req", {31'd0, psg_req}, 32'd0);
    chk("rst_left", {8'd0, left_data}, 32'd0);
    chk("rst_right", {8'd0, right_data}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_pcm_un", {24'd0, pcm_underruns}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Immediate acks, latency check.
    set_src(16'h1000, 16'hF000, 16'h0100, 16'h0100);
    sb.push_back({24'h088000, 24'hF88000});
    pulse();
    chk("lat_pcm_req", {31'd0, pcm_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("lat_early", {8'd0, left_data}, 32'd0);
    @(negedge clk);
    pop_chk("basic");

    // PCM timeout, PSG acks.
    pcm_mode = 1;
    set_src(16'h1234, 16'h4321, 16'h2000, 16'h2000);
    sb.push_back({24'h100000, 24'h100000});
    pulse();
    c = 0;
    while (pcm_req && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk("tmo_req_len", c, T);
    wait_done("tmo");
    pop_chk("tmo");
    chk("tmo_un", {24'd0, pcm_underruns}, 32'd1);
    chk("tmo_psg_un", {24'd0, psg_underruns}, 32'd0);

    // Ack on the timeout cycle wins.
    pcm_mode = 2;
    pcm_dly = T - 1;
    set_src(16'h0010, 16'hFFF0, 16'h0000, 16'h0000);
    frame("edge", 24'h000800, 24'hFFF800);
    chk("edge_un", {24'd0, pcm_underruns}, 32'd1);
    pcm_mode = 0;

    // Full-scale extremes.
    set_src(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
    frame("ext", 24'h7FFF00, 24'h800000);

    // Arithmetic attenuation.
    pcm_att = 4'd4;
    set_src(16'h8000, 16'h8000, 16'h0000, 16'h0000);
    frame("att_pcm", 24'hFC0000, 24'hFC0000);
    pcm_att = 4'd0;
    psg_att = 4'd1;
    set_src(16'h0000, 16'h0000, 16'h0200, 16'hFE00);
    frame("att_psg", 24'h008000, 24'hFF8000);
    psg_att = 4'd0;

    // Mute.
    mute = 1'b1;
    set_src(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    frame("mute", 24'h000000, 24'h000000);
    mute = 1'b0;

    // Overrun: second pulse 3 cycles later.
    set_src(16'h0400, 16'h0200, 16'h0000, 16'h0000);
    r0 = pcm_rises;
    sb.push_back({24'h020000, 24'h010000});
    pulse();
    @(negedge clk);
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    pop_chk("ovr");
    repeat (10) @(negedge clk);
    chk("ovr_seq", pcm_rises - r0, 1);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    clr_pulse();
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
    chk("clr_un", {24'd0, pcm_underruns}, 32'd0);

    // Reset in the middle of REQ_PSG.
    psg_mode = 1;
    pulse();
    @(negedge clk);
    chk("mid_psg_req", {31'd0, psg_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_psg_drop", {31'd0, psg_req}, 32'd0);
    chk("mid_pcm_drop", {31'd0, pcm_req}, 32'd0);
    chk("mid_left", {8'd0, left_data}, 32'd0);
    chk("mid_right", {8'd0, right_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    psg_mode = 0;
    set_src(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    frame("post_rst", 24'h010000, 24'h008000);
    chk("post_rst_un", {24'd0, psg_underruns}, 32'd0);

    // Saturate the PCM underrun counter.
    pcm_mode = 1;
    set_src(16'h0000, 16'h0000, 16'h0001, 16'hFFFF);
    for (int i = 0; i < 255; i++) begin
      pulse();
      wait_done("sat");
    end
    chk("sat_255", {24'd0, pcm_underruns}, 32'd255);
    frame("sat_last", 24'h000080, 24'hFFFF80);
    chk("sat_hold", {24'd0, pcm_underruns}, 32'd255);
    clr_pulse();
    chk("sat_clr", {24'd0, pcm_underruns}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/audio_sample_sched.md
# audio_sample_sched

Sequences per-frame sample collection for the I2S DAC interface. Each frame, the DAC interface issues a `next_sample` pulse. On that pulse this block fetches one stereo sample from the PCM source and then one from the PSG source over req/ack handshakes. It attenuates and sums the two samples and presents the result as stable 24-bit left/right words. Those words are consumed on the following `next_sample`. A missing source yields silence for its contribution, and the event is counted.

## Interface
- `TIMEOUT`, 32: maximum cycles to wait for a source ack. Legal range is 2..63.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next_sample`  in  1  single-cycle frame pulse from the DAC interface.
- `pcm_req`  out  1  PCM sample request (level).
- `pcm_ack`  in  1  PCM data valid. Sampled only while `pcm_req`=1.
- `pcm_left`, `pcm_right`  in  16 each  signed PCM sample.
- `psg_req`  out  1  PSG sample request (level).
- `psg_ack`  in  1  PSG data valid. Sampled only while `psg_req`=1.
- `psg_left`, `psg_right`  in  16 each  signed PSG sample.
- `pcm_att`, `psg_att`  in  4 each  arithmetic right-shift attenuation (0 = unity).
- `mute`  in  1  forces mix to zero. Sampled in MIX.
- `left_data`, `right_data`  out  24 each  signed mixed sample to the DAC interface.
- `pcm_underruns`, `psg_underruns`  out  8 each  saturating timeout counters.
- `overrun`  out  1  sticky: `next_sample` arrived while not IDLE.
- `stat_clr`  in  1  synchronous clear of both counters and `overrun`.

## Operation
- FSM states: IDLE, REQ_PCM, REQ_PSG, MIX.
  - IDLE --`next_sample`--> REQ_PCM.
  - REQ_PCM --ack or timeout--> REQ_PSG.
  - REQ_PSG --ack or timeout--> MIX.
  - MIX --> IDLE (always, one cycle).
- In REQ_x:
  - `x_req`=1, and the wait counter increments each cycle.
  - On `x_ack`=1: capture both channels, then move on.
  - If the counter reaches `TIMEOUT`-1 without an ack: captured data := 0, `x_underruns` increments (saturates at 255), then move on.
  - The counter clears on state entry.
- An ack arriving outside REQ_x is ignored. `x_req` deasserts in the cycle after the accepted ack or timeout.
- Mix arithmetic, per channel:
  - s = (pcm >>> pcm_att) + (psg >>> psg_att).
  - Operands are sign-extended to 17 bits, so the sum is exact and needs no saturation.
  - Output = {s[16:0], 7'b0}.
  - If `mute`=1, output = 0.
- `left_data`/`right_data` update only in MIX and hold at all other times.
- `next_sample` while not IDLE:
  - `overrun` is set.
  - The pulse is dropped; the in-flight sequence completes unchanged.
- `stat_clr` has priority over a same-cycle increment or set.

## Timing
- Reset values:
  - state IDLE.
  - `pcm_req`=`psg_req`=0.
  - `left_data`=`right_data`=0.
  - counters 0, `overrun`=0.
- `pcm_req` rises 1 cycle after `next_sample` (registered).
- Immediate acks give the best-case sequence `next_sample`, REQ_PCM, REQ_PSG, MIX. Outputs are valid 4 cycles after `next_sample`.
- Worst-case sequence length is 2*`TIMEOUT`+2 cycles. This must be less than the frame length of 128 clocks.
- Mixed data has a latency of one frame. It is consumed by the DAC interface at the next `next_sample`.
- Ack in the same cycle as the timeout edge: the ack wins and no underrun is counted.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous). The next frame starts from IDLE.

## Structure
- Shared package `audio_pkg`:
  - state enum.
  - sample width constants: 16 in, 17 mix, 24 out.
  - default `TIMEOUT`.
- One natural sub-module, `audio_src_fetch`: req/ack/timeout handshake plus capture registers and saturating underrun counter. Instantiated twice (PCM, PSG) and sequenced by the top-level FSM.

## Test plan
- Immediate acks; pcm=(0x1000, 0xF000), psg=(0x0100, 0x0100), att=0:
  - left_data=0x088000, right_data=0xF88000.
  - Valid 4 cycles after `next_sample`.
- PCM never acks, PSG acks with (0x2000, 0x2000):
  - `pcm_req` held exactly `TIMEOUT` cycles.
  - `pcm_underruns`=1.
  - output = 0x100000 on both channels.
- pcm=0x7FFF, psg=0x7FFF, att=0 → left_data=0x7FFF00 (no wrap). pcm=0x8000, psg=0x8000 → 0x800000.
- `pcm_att`=4, pcm=0x8000, psg=0 → output 0xFC0000 (arithmetic shift).
- Two `next_sample` pulses 3 cycles apart → `overrun`=1, only one fetch sequence. `stat_clr` then clears `overrun`.
- Reset pulse mid-REQ_PSG → reqs drop asynchronously, outputs 0. The next `next_sample` runs a clean sequence. 256 consecutive timeouts → counter saturates at 255.
